// File: rtl/spi_frame_decoder.sv
// rtl/spi_frame_decoder.sv - synchronizes SPI chip-enable and decodes SYNC/CMD/ARG/CHECKSUM frames
module spi_frame_decoder #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic [7:0] spi_data,
    output logic       byte_stb,
    output logic       cmd_valid,
    output logic [7:0] cmd,
    output logic [7:0] arg,
    output logic       frame_err,
    output logic [7:0] err_count
);

    localparam int            CW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {WAIT_SYNC, GET_CMD, GET_ARG, GET_CSUM} state_t;

    state_t        state_q, state_d;
    logic          ce_s1_q, ce_s2_q, ce_s3_q;
    logic          byte_stb_q, byte_stb_d;
    logic [7:0]    byte_q, byte_d;
    logic [7:0]    cmd_tmp_q, cmd_tmp_d, arg_tmp_q, arg_tmp_d;
    logic [7:0]    cmd_q, cmd_d, arg_q, arg_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          frame_err_q, frame_err_d;
    logic [7:0]    err_count_q, err_count_d;
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic          byte_evt, err_inc;

    // Falling edge of the synchronized chip-enable marks a completed byte.
    assign byte_evt = ~ce_s2_q & ce_s3_q;

    always_comb begin
        state_d     = state_q;
        byte_stb_d  = byte_evt;
        byte_d      = byte_evt ? spi_data : byte_q;
        cmd_tmp_d   = cmd_tmp_q;
        arg_tmp_d   = arg_tmp_q;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;
        err_inc     = 1'b0;
        tcnt_d      = tcnt_q;

        // A byte arriving on the timeout cycle takes precedence over the timeout.
        if (byte_stb_q) begin
            tcnt_d = '0;
            unique case (state_q)
                WAIT_SYNC: if (byte_q == SYNC_BYTE) state_d = GET_CMD;
                GET_CMD: begin
                    cmd_tmp_d = byte_q;
                    state_d   = GET_ARG;
                end
                GET_ARG: begin
                    arg_tmp_d = byte_q;
                    state_d   = GET_CSUM;
                end
                GET_CSUM: begin
                    if (byte_q == (SYNC_BYTE ^ cmd_tmp_q ^ arg_tmp_q)) begin
                        cmd_d       = cmd_tmp_q;
                        arg_d       = arg_tmp_q;
                        cmd_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_inc     = 1'b1;
                    end
                    state_d = WAIT_SYNC;
                end
                default: state_d = WAIT_SYNC;
            endcase
        end else if (state_q != WAIT_SYNC && tcnt_q == TMAX) begin
            state_d     = WAIT_SYNC;
            frame_err_d = 1'b1;
            err_inc     = 1'b1;
            tcnt_d      = '0;
        end else if (state_q == WAIT_SYNC) begin
            tcnt_d = '0;
        end else begin
            tcnt_d = tcnt_q + CW'(1);
        end

        err_count_d = (err_inc && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= WAIT_SYNC;
            ce_s1_q     <= 1'b0;
            ce_s2_q     <= 1'b0;
            ce_s3_q     <= 1'b0;
            byte_stb_q  <= 1'b0;
            byte_q      <= 8'h00;
            cmd_tmp_q   <= 8'h00;
            arg_tmp_q   <= 8'h00;
            cmd_q       <= 8'h00;
            arg_q       <= 8'h00;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= 8'h00;
            tcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            ce_s1_q     <= ce;
            ce_s2_q     <= ce_s1_q;
            ce_s3_q     <= ce_s2_q;
            byte_stb_q  <= byte_stb_d;
            byte_q      <= byte_d;
            cmd_tmp_q   <= cmd_tmp_d;
            arg_tmp_q   <= arg_tmp_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
            tcnt_q      <= tcnt_d;
        end
    end

    assign byte_stb  = byte_stb_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign arg       = arg_q;
    assign frame_err = frame_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_spi_frame_decoder.sv
// tb/tb_spi_frame_decoder.sv - directed self-checking bench for spi_frame_decoder
module tb_spi_frame_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ce = 1'b0;
    logic [7:0] spi_data = 8'h00;
    logic       byte_stb, cmd_valid, frame_err;
    logic [7:0] cmd, arg, err_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_stb = 0, n_val = 0, n_err = 0;
    int stb_cyc = 0, val_cyc = 0, err_cyc = 0, fall_cyc = 0;

    spi_frame_decoder #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .ce(ce), .spi_data(spi_data),
        .byte_stb(byte_stb), .cmd_valid(cmd_valid), .cmd(cmd), .arg(arg),
        .frame_err(frame_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byte_stb)  begin n_stb++; stb_cyc = cyc; end
        if (cmd_valid) begin n_val++; val_cyc = cyc; end
        if (frame_err) begin n_err++; err_cyc = cyc; end
    end

    task automatic clear_counts();
        n_stb = 0; n_val = 0; n_err = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        spi_data = b;
        ce = 1'b1;
        repeat (3) @(negedge clk);
        ce = 1'b0;
        fall_cyc = cyc;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] cs);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(a);
        send_byte(cs);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({byte_stb, cmd_valid, frame_err} !== 3'b000 || cmd !== 8'h00 || arg !== 8'h00 || err_count !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got stb/val/err=%b%b%b cmd=%h arg=%h cnt=%h, want all zero",
                     byte_stb, cmd_valid, frame_err, cmd, arg, err_count);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_frame();
        clear_counts();
        send_frame(8'h12, 8'h34, 8'h83);
        checks++;
        if (n_stb !== 4) begin errors++; $display("FAIL good_stb_count: got %0d want 4", n_stb); end
        checks++;
        if (stb_cyc - fall_cyc !== 3) begin errors++; $display("FAIL ce_to_stb_latency: got %0d want 3", stb_cyc - fall_cyc); end
        checks++;
        if (n_val !== 1) begin errors++; $display("FAIL good_val_count: got %0d want 1", n_val); end
        checks++;
        if (val_cyc - stb_cyc !== 1) begin errors++; $display("FAIL val_latency: got %0d want 1", val_cyc - stb_cyc); end
        checks++;
        if (cmd !== 8'h12 || arg !== 8'h34) begin errors++; $display("FAIL good_cmd_arg: got %h/%h want 12/34", cmd, arg); end
        checks++;
        if (err_count !== 8'h00 || n_err !== 0) begin errors++; $display("FAIL good_no_err: got cnt=%h pulses=%0d want 00/0", err_count, n_err); end
    endtask

    task automatic test_bad_checksum();
        clear_counts();
        send_frame(8'h12, 8'h34, 8'h00);
        checks++;
        if (n_err !== 1 || err_count !== 8'h01) begin errors++; $display("FAIL bad_csum_err: got pulses=%0d cnt=%h want 1/01", n_err, err_count); end
        checks++;
        if (err_cyc - stb_cyc !== 1) begin errors++; $display("FAIL bad_csum_latency: got %0d want 1", err_cyc - stb_cyc); end
        checks++;
        if (n_val !== 0 || cmd !== 8'h12 || arg !== 8'h34) begin errors++; $display("FAIL bad_csum_hold: got val=%0d cmd=%h arg=%h want 0/12/34", n_val, cmd, arg); end
    endtask

    task automatic test_sync_hunt();
        logic [7:0] seq [6] = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h02, 8'hA6};
        clear_counts();
        for (int i = 0; i < 6; i++) send_byte(seq[i]);
        checks++;
        if (n_stb !== 6) begin errors++; $display("FAIL hunt_stb_count: got %0d want 6", n_stb); end
        checks++;
        if (n_val !== 1 || cmd !== 8'h01 || arg !== 8'h02) begin errors++; $display("FAIL hunt_decode: got val=%0d cmd=%h arg=%h want 1/01/02", n_val, cmd, arg); end
        checks++;
        if (n_err !== 0 || err_count !== 8'h01) begin errors++; $display("FAIL hunt_no_err: got pulses=%0d cnt=%h want 0/01", n_err, err_count); end
    endtask

    task automatic test_timeout();
        clear_counts();
        send_byte(8'hA5);
        send_byte(8'h07);
        repeat (30) @(negedge clk);
        checks++;
        if (n_err !== 1 || err_count !== 8'h02) begin errors++; $display("FAIL timeout_err: got pulses=%0d cnt=%h want 1/02", n_err, err_count); end
        checks++;
        if (err_cyc - stb_cyc !== 17) begin errors++; $display("FAIL timeout_latency: got %0d want 17", err_cyc - stb_cyc); end
        checks++;
        if (n_val !== 0) begin errors++; $display("FAIL timeout_no_val: got %0d want 0", n_val); end
        clear_counts();
        send_frame(8'h55, 8'h66, 8'h96);
        checks++;
        if (n_val !== 1 || cmd !== 8'h55 || arg !== 8'h66 || n_err !== 0) begin
            errors++;
            $display("FAIL after_timeout_decode: got val=%0d cmd=%h arg=%h errp=%0d want 1/55/66/0", n_val, cmd, arg, n_err);
        end
    endtask

    task automatic test_saturation();
        clear_counts();
        for (int i = 0; i < 300; i++) send_frame(8'h01, 8'h02, 8'h00);
        checks++;
        if (err_count !== 8'hFF) begin errors++; $display("FAIL saturate_count: got %h want ff", err_count); end
        checks++;
        if (n_err !== 300 || n_val !== 0) begin errors++; $display("FAIL saturate_pulses: got err=%0d val=%0d want 300/0", n_err, n_val); end
        checks++;
        if (cmd !== 8'h55 || arg !== 8'h66) begin errors++; $display("FAIL saturate_hold: got %h/%h want 55/66", cmd, arg); end
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'hA5);
        send_byte(8'h12);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd !== 8'h00 || arg !== 8'h00 || err_count !== 8'h00 || cmd_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got cmd=%h arg=%h cnt=%h val=%b err=%b want zeros", cmd, arg, err_count, cmd_valid, frame_err);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        clear_counts();
        send_byte(8'h34);
        send_byte(8'h26);
        checks++;
        if (n_val !== 0 || n_err !== 0 || n_stb !== 2) begin
            errors++;
            $display("FAIL midreset_orphans: got val=%0d err=%0d stb=%0d want 0/0/2", n_val, n_err, n_stb);
        end
        send_frame(8'h12, 8'h34, 8'h83);
        checks++;
        if (n_val !== 1 || cmd !== 8'h12 || arg !== 8'h34 || err_count !== 8'h00) begin
            errors++;
            $display("FAIL midreset_recover: got val=%0d cmd=%h arg=%h cnt=%h want 1/12/34/00", n_val, cmd, arg, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_sync_hunt();
        test_timeout();
        test_saturation();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
